// File: rtl/snake_pkg.sv
// snake_pkg: direction and FSM encodings plus default arena bounds shared by the snake engine.
package snake_pkg;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  localparam int ARENA_MAX_X = 95;
  localparam int ARENA_MAX_Y = 63;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction
endpackage

// File: rtl/snake_body_buf.sv
// snake_body_buf: circular segment position buffer, one write port, one indexed read plus full view.
module snake_body_buf #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  slow_clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [9:0]            wx,
  input  logic [9:0]            wy,
  input  logic [AW-1:0]         raddr,
  output logic [9:0]            rx,
  output logic [9:0]            ry,
  output logic [DEPTH-1:0][9:0] all_x,
  output logic [DEPTH-1:0][9:0] all_y
);
  logic [DEPTH-1:0][9:0] mx, my;
  always_ff @(posedge slow_clk)
    if (we) begin
      mx[waddr] <= wx;
      my[waddr] <= wy;
    end
  assign rx = mx[raddr];
  assign ry = my[raddr];
  assign all_x = mx;
  assign all_y = my;
endmodule

// File: rtl/snake_engine.sv
// snake_engine: snake game core -- step divider, heading control, wall handling, growth and self-collision.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_X     = ARENA_MAX_X,
  parameter int MAX_Y     = ARENA_MAX_Y,
  parameter int MAX_LEN   = 16,
  parameter int STEP_DIV  = 16,
  parameter int WALL_MODE = 0,
  parameter int INIT_X    = 48,
  parameter int INIT_Y    = 32
) (
  input  logic                       slow_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       dir_valid,
  input  logic [1:0]                 dir,
  input  logic                       grow,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [9:0]                 rd_x,
  output logic [9:0]                 rd_y,
  output logic [9:0]                 head_x,
  output logic [9:0]                 head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       step,
  output logic                       wall_hit,
  output logic                       game_over
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(STEP_DIV);
  localparam logic signed [10:0] LX = 11'(MAX_X);
  localparam logic signed [10:0] LY = 11'(MAX_Y);

  state_t state, nstate;
  dir_t heading, pend, new_dir;
  logic [DW-1:0] div;
  logic [AW-1:0] ptr;
  logic grow_pend, entry, step_c, off_x, off_y, wall, grows, hit;
  logic signed [10:0] ax, ay, bx, by;
  logic [9:0] nx, ny, buf_x, buf_y;
  logic [LW-1:0] lim;
  logic [MAX_LEN-1:0][9:0] all_x, all_y;

  assign entry  = state != RUN && start;
  assign step_c = state == RUN && div == DW'(STEP_DIV - 1);

  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  always_comb nstate = entry ? RUN : step_c && hit ? OVER : state;

  always_comb begin
    step      = step_c;
    wall_hit  = step_c && wall;
    game_over = state == OVER;
  end

  // Candidate move in signed space so both edges can be detected before folding back.
  always_comb begin
    ax = $signed({1'b0, head_x}) + (pend == RIGHT ? 11'sd1 : pend == LEFT ? -11'sd1 : 11'sd0);
    ay = $signed({1'b0, head_y}) + (pend == DOWN ? 11'sd1 : pend == UP ? -11'sd1 : 11'sd0);
    off_x = ax < 11'sd0 || ax > LX;
    off_y = ay < 11'sd0 || ay > LY;
    bx = !off_x ? ax : WALL_MODE == 0 ? (ax < 11'sd0 ? 11'sd0 : LX) : (ax < 11'sd0 ? LX : 11'sd0);
    by = !off_y ? ay : WALL_MODE == 0 ? (ay < 11'sd0 ? 11'sd0 : LY) : (ay < 11'sd0 ? LY : 11'sd0);
    nx = 10'(bx);
    ny = 10'(by);
    wall = off_x || off_y;
    new_dir = wall && WALL_MODE == 0 ? opposite(pend) : pend;
  end

  // Old segments that stay live after the move; the tail is excluded unless the snake grows.
  assign grows = grow_pend && length < LW'(MAX_LEN);
  assign lim   = grows ? length : length - LW'(1);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++)
      if (LW'(AW'(ptr - AW'(k))) < lim && all_x[k] == nx && all_y[k] == ny) hit = 1'b1;
  end

  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n) begin
      head_x    <= 10'(INIT_X);
      head_y    <= 10'(INIT_Y);
      length    <= LW'(1);
      heading   <= RIGHT;
      pend      <= RIGHT;
      div       <= '0;
      grow_pend <= 1'b0;
      ptr       <= '0;
    end else if (entry) begin
      head_x    <= 10'(INIT_X);
      head_y    <= 10'(INIT_Y);
      length    <= LW'(1);
      heading   <= RIGHT;
      pend      <= RIGHT;
      div       <= '0;
      grow_pend <= 1'b0;
    end else if (state == RUN) begin
      div       <= step_c ? '0 : div + 1'b1;
      grow_pend <= step_c ? grow : grow_pend || grow;
      if (step_c) begin
        head_x  <= nx;
        head_y  <= ny;
        heading <= new_dir;
        pend    <= new_dir;
        ptr     <= ptr + 1'b1;
        length  <= length + LW'(grows);
      end else if (dir_valid && !(length > LW'(1) && dir_t'(dir) == opposite(heading)))
        pend <= dir_t'(dir);
    end

  // The head cell is written on game entry so segment 0 always lives at ptr during play.
  snake_body_buf #(.DEPTH(MAX_LEN)) u_body (
    .slow_clk(slow_clk),
    .we(entry || step_c),
    .waddr(step_c ? ptr + 1'b1 : ptr),
    .wx(step_c ? nx : 10'(INIT_X)),
    .wy(step_c ? ny : 10'(INIT_Y)),
    .raddr(ptr - rd_idx),
    .rx(buf_x),
    .ry(buf_y),
    .all_x(all_x),
    .all_y(all_y)
  );

  assign rd_x = LW'(rd_idx) >= length ? '0 : rd_idx == '0 ? head_x : buf_x;
  assign rd_y = LW'(rd_idx) >= length ? '0 : rd_idx == '0 ? head_y : buf_y;
endmodule
